// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        misaligned;
  } fq_entry_t;

  typedef enum logic [0:0] {
    FS_RUN  = 1'b0,
    FS_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetched entries with push, pop, flush and occupancy count.
// A flush empties the queue; a push in the same cycle lands as the sole entry.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush_i,
  input  logic             push_i,
  input  fq_entry_t        push_entry_i,
  input  logic             pop_i,
  output fq_entry_t        head_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  fq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] wr_idx;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign do_push = push_i & (flush_i | ~full);
  assign do_pop  = pop_i & ~flush_i & ~empty_o;
  assign wr_idx  = flush_i ? '0 : wr_q;
  assign head_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = do_push ? ptr_inc('0) : '0;
      cnt_d = CNT_W'(do_push);
    end else begin
      if (do_push) wr_d = ptr_inc(wr_q);
      if (do_pop)  rd_d = ptr_inc(rd_q);
      cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_idx] <= push_entry_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: credit-limited imem requests, in-order responses
// into a fetch queue, redirect flush with drop counting of stale responses.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect enqueues a fault entry
// and halts issue until the next redirect.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned FQ_DEPTH = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        id_ready,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_misaligned
);

  localparam int unsigned CNT_W = $clog2(FQ_DEPTH + 1);

  fetch_state_e     state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic [CNT_W-1:0] fq_count;
  logic [CNT_W:0]   credits_used;
  logic [31:0]      redir_target;
  logic             deq;
  logic             gnt_fire;
  logic             redir_mis;
  logic             fq_push;
  logic             fq_empty;
  fq_entry_t        fq_head;
  fq_entry_t        fq_push_entry;

  assign redir_target = {redirect_pc[31:2], 2'b00};

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_mis     = redirect_valid & (redirect_pc[1:0] != 2'b00);
  assign if_misaligned = if_valid & fq_head.misaligned;
`else
  logic unused_align;
  assign redir_mis     = 1'b0;
  assign unused_align  = ^{redirect_pc[1:0], fq_head.misaligned};
  assign if_misaligned = 1'b0;
`endif

  // The slot freed by a dequeue this cycle counts as a credit; since credits
  // only shrink through a grant, a raised request stays up until granted.
  assign deq          = if_valid & id_ready;
  assign credits_used = {1'b0, fq_count} + {1'b0, out_q} - (CNT_W + 1)'(deq);
  assign imem_req     = resetn && (state_q == FS_RUN) &&
                        (credits_used < (CNT_W + 1)'(FQ_DEPTH));
  assign imem_addr    = pc_q;
  assign gnt_fire     = imem_req & imem_gnt;

  assign if_valid = ~fq_empty;
  assign if_pc    = if_valid ? fq_head.pc    : '0;
  assign if_instr = if_valid ? fq_head.instr : NOP_INSTR;

  fetch_queue #(
    .DEPTH (FQ_DEPTH)
  ) u_fetch_queue (
    .clk          (clk),
    .resetn       (resetn),
    .flush_i      (redirect_valid),
    .push_i       (fq_push),
    .push_entry_i (fq_push_entry),
    .pop_i        (deq),
    .head_o       (fq_head),
    .empty_o      (fq_empty),
    .count_o      (fq_count)
  );

  // Redirect outranks grant/response bookkeeping; every request still in
  // flight after this cycle belongs to the old stream and gets dropped.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    resp_pc_d     = resp_pc_q;
    out_d         = out_q + CNT_W'(gnt_fire) - CNT_W'(imem_rvalid);
    drop_d        = drop_q;
    fq_push       = 1'b0;
    fq_push_entry = '{pc: resp_pc_q, instr: imem_rdata, misaligned: 1'b0};
    if (gnt_fire) pc_d = pc_q + 32'd4;
    if (redirect_valid) begin
      pc_d      = redir_target;
      resp_pc_d = redir_target;
      drop_d    = out_d;
      state_d   = FS_RUN;
      if (redir_mis) begin
        state_d       = FS_HALT;
        fq_push       = 1'b1;
        fq_push_entry = '{pc: redirect_pc, instr: NOP_INSTR, misaligned: 1'b1};
      end
    end else if (imem_rvalid) begin
      if (drop_q != '0) begin
        drop_d = drop_q - 1'b1;
      end else begin
        fq_push   = 1'b1;
        resp_pc_d = resp_pc_q + 32'd4;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= FS_RUN;
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

endmodule
